fwd_hazard_ctrl: RTL and testbench

- Parametrised forwarding and hazard controller for the 5-stage pipeline.
- Keeps its own shadow pipeline of destination and source register tags for the EX, MEM and WB stages, advanced in lockstep with the datapath pipeline registers.
- From those tags it generates, per EX source operand:
  - EX-to-EX forwarding selects;
  - MEM-to-EX forwarding selects;
  - the MEM-to-MEM store-data forward enable;
  - the load-use stall request;
  - a saturating stall counter.

---
 rtl/fwd_hazard_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// fwd_hazard_ctrl
//   Forwarding and load-use hazard controller for a 5-stage pipeline. It keeps
//   a shadow copy of the register tags held in the EX, MEM and WB pipeline
//   registers. From those tags it produces operand forwarding selects, a
//   store-data forward enable and a one-cycle load-use stall.
//
// Ports
//   clk, rst      clock and synchronous active-high reset
//   id_valid      ID stage holds a real instruction
//   id_rs         packed source tags, source i at [i*REG_ADDR_W +: REG_ADDR_W]
//   id_rs_used    bit i set when source i is actually read
//   id_rd         destination tag of the ID instruction
//   id_regwrite   ID instruction writes the register file
//   id_memread    ID instruction is a load
//   id_memwrite   ID instruction is a store
//   flush         squash the ID instruction (taken branch)
//   stall         hold PC and IF/ID, inject a bubble into EX
//   ex_fwd_sel    per-source select: 00 reg file, 10 EX/MEM, 01 MEM/WB
//   mem_fwd_en    use the WB result as store data in MEM
//   stall_count   saturating count of cycles with stall asserted
// ---------------------------------------------------------------------------
module fwd_hazard_ctrl #(
    parameter int REG_ADDR_W = 4,
    parameter int NUM_SRC    = 2,
    parameter int STORE_SRC  = 1,
    parameter bit MEM_FWD_EN = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          id_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs,
    input  logic [NUM_SRC-1:0]            id_rs_used,
    input  logic [REG_ADDR_W-1:0]         id_rd,
    input  logic                          id_regwrite,
    input  logic                          id_memread,
    input  logic                          id_memwrite,
    input  logic                          flush,
    output logic                          stall,
    output logic [NUM_SRC*2-1:0]          ex_fwd_sel,
    output logic                          mem_fwd_en,
    output logic [CNT_W-1:0]              stall_count
);

    // Hit pattern meaning "only the store-data source matched".
    localparam logic [NUM_SRC-1:0] STORE_ONLY = NUM_SRC'(1) << STORE_SRC;

    typedef struct packed {
        logic                                valid;
        logic [REG_ADDR_W-1:0]               rd;
        logic                                regwrite;
        logic                                memread;
        logic                                memwrite;
        logic [NUM_SRC-1:0][REG_ADDR_W-1:0]  rs;
        logic [NUM_SRC-1:0]                  rs_used;
    } ex_rec_t;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  regwrite;
        logic                  memread;
        logic                  memwrite;
        logic [REG_ADDR_W-1:0] sd;        // store-data source tag
    } mem_rec_t;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  regwrite;
    } wb_rec_t;

    ex_rec_t            ex_d,  ex_q;
    mem_rec_t           mem_d, mem_q;
    wb_rec_t            wb_d,  wb_q;
    logic [CNT_W-1:0]   cnt_d, cnt_q;

    logic               ex_writer, mem_writer, wb_writer;
    logic [NUM_SRC-1:0] src_hit;
    logic               store_exempt;
    logic               hazard;

    // A stage only counts as a producer if it really writes a non-zero register.
    assign ex_writer  = ex_q.valid  && ex_q.regwrite  && (ex_q.rd  != '0);
    assign mem_writer = mem_q.valid && mem_q.regwrite && (mem_q.rd != '0);
    assign wb_writer  = wb_q.valid  && wb_q.regwrite  && (wb_q.rd  != '0);

    // NOTE: every signal driven in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        src_hit = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_hit[i] = id_rs_used[i] &&
                         (id_rs[i*REG_ADDR_W +: REG_ADDR_W] == ex_q.rd);
        end
    end

    // A store that depends on the load only through its data operand can take
    // the loaded value in MEM from WB instead of waiting a cycle.
    assign store_exempt = MEM_FWD_EN && id_memwrite && (src_hit == STORE_ONLY);
    assign hazard       = ex_writer && ex_q.memread && (|src_hit) && !store_exempt;
    assign stall        = id_valid && hazard && !flush;

    // Next EX record: bubble on stall, flush or empty ID slot.
    always_comb begin
        ex_d = '0;
        if (id_valid && !stall && !flush) begin
            ex_d.valid    = 1'b1;
            ex_d.rd       = id_rd;
            ex_d.regwrite = id_regwrite;
            ex_d.memread  = id_memread;
            ex_d.memwrite = id_memwrite;
            ex_d.rs       = id_rs;
            ex_d.rs_used  = id_rs_used;
        end
    end

    // MEM and WB advance every cycle regardless of stall.
    always_comb begin
        mem_d          = '0;
        mem_d.valid    = ex_q.valid;
        mem_d.rd       = ex_q.rd;
        mem_d.regwrite = ex_q.regwrite;
        mem_d.memread  = ex_q.memread;
        mem_d.memwrite = ex_q.memwrite;
        mem_d.sd       = ex_q.rs[STORE_SRC];

        wb_d           = '0;
        wb_d.valid     = mem_q.valid;
        wb_d.rd        = mem_q.rd;
        wb_d.regwrite  = mem_q.regwrite;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // MEM is checked first so the youngest producer wins.
    always_comb begin
        ex_fwd_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (ex_q.rs_used[i] && mem_writer && (mem_q.rd == ex_q.rs[i])) begin
                ex_fwd_sel[2*i +: 2] = 2'b10;
            end else if (ex_q.rs_used[i] && wb_writer && (wb_q.rd == ex_q.rs[i])) begin
                ex_fwd_sel[2*i +: 2] = 2'b01;
            end
        end
    end

    assign mem_fwd_en  = MEM_FWD_EN && mem_q.valid && mem_q.memwrite &&
                         wb_writer && (wb_q.rd == mem_q.sd);
    assign stall_count = cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
            cnt_q <= cnt_d;
        end
    end

    // A load in MEM must never feed a used EX source: the stall should have
    // prevented that, except for the store-data operand forwarded in MEM.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                assert (!(mem_writer && mem_q.memread && ex_q.rs_used[i] &&
                          (mem_q.rd == ex_q.rs[i])) ||
                        (MEM_FWD_EN && (i == STORE_SRC) && ex_q.memwrite));
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fwd_hazard_ctrl
//   Drives two controllers from the same ID stream: one with store-data MEM
//   forwarding enabled and a 4-bit stall counter, one with it disabled and a
//   16-bit counter. A reference model holds each pipeline as a list of issued
//   instructions (EX, MEM, WB) and derives outputs from the hazard rules.
// ---------------------------------------------------------------------------
module tb_fwd_hazard_ctrl;

    typedef struct packed {
        logic             valid;
        logic [3:0]       rd;
        logic             rw;
        logic             mr;
        logic             mw;
        logic [1:0][3:0]  rs;
        logic [1:0]       used;
    } instr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [7:0]  id_rs;
    logic [1:0]  id_rs_used;
    logic [3:0]  id_rd;
    logic        id_regwrite, id_memread, id_memwrite, flush;

    logic        stall1, stall0, mfe1, mfe0;
    logic [3:0]  sel1, sel0;
    logic [3:0]  cnt1;
    logic [15:0] cnt0;

    int n_cmp = 0;
    int n_err = 0;

    // Model: pipe[m][0] = EX, [1] = MEM, [2] = WB; m=1 is the forwarding build.
    instr_t      pipe [2][3];
    int unsigned cnt  [2];

    always #5 clk = ~clk;

    fwd_hazard_ctrl #(.REG_ADDR_W(4), .NUM_SRC(2), .STORE_SRC(1),
                      .MEM_FWD_EN(1'b1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs),
        .id_rs_used(id_rs_used), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_memwrite(id_memwrite), .flush(flush),
        .stall(stall1), .ex_fwd_sel(sel1), .mem_fwd_en(mfe1), .stall_count(cnt1)
    );

    fwd_hazard_ctrl #(.REG_ADDR_W(4), .NUM_SRC(2), .STORE_SRC(1),
                      .MEM_FWD_EN(1'b0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs),
        .id_rs_used(id_rs_used), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_memwrite(id_memwrite), .flush(flush),
        .stall(stall0), .ex_fwd_sel(sel0), .mem_fwd_en(mfe0), .stall_count(cnt0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic producer(instr_t r);
        return r.valid && r.rw && (r.rd != 4'd0);
    endfunction

    function automatic instr_t id_instr();
        instr_t r;
        r.valid = id_valid;
        r.rd    = id_rd;
        r.rw    = id_regwrite;
        r.mr    = id_memread;
        r.mw    = id_memwrite;
        r.rs    = id_rs;
        r.used  = id_rs_used;
        return r;
    endfunction

    // Load-use rule: the load in EX feeds a used ID source, unless (with MEM
    // forwarding) the ID instruction is a store depending only via source 1.
    function automatic logic model_stall(int m);
        instr_t ld = pipe[m][0];
        instr_t id = id_instr();
        int     hits = 0;
        logic   store_hit = 1'b0;
        if (!id_valid || flush) return 1'b0;
        if (!(producer(ld) && ld.mr)) return 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (id.used[i] && id.rs[i] == ld.rd) begin
                hits++;
                if (i == 1) store_hit = 1'b1;
            end
        end
        if (hits == 0) return 1'b0;
        if (m == 1 && id.mw && hits == 1 && store_hit) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [3:0] model_sel(int m);
        instr_t ex = pipe[m][0];
        int     code = 0;
        for (int i = 0; i < 2; i++) begin
            if (ex.used[i] && producer(pipe[m][1]) && pipe[m][1].rd == ex.rs[i])
                code += 2 << (2 * i);
            else if (ex.used[i] && producer(pipe[m][2]) && pipe[m][2].rd == ex.rs[i])
                code += 1 << (2 * i);
        end
        return 4'(code);
    endfunction

    function automatic logic model_mfe(int m);
        instr_t st = pipe[m][1];
        return (m == 1) && st.valid && st.mw && producer(pipe[m][2]) &&
               (pipe[m][2].rd == st.rs[1]);
    endfunction

    task automatic drive(input logic v, input logic [3:0] rs0, input logic [3:0] rs1,
                         input logic [1:0] used, input logic [3:0] rd, input logic rw,
                         input logic mr, input logic mw, input logic fl);
        id_valid    = v;
        id_rs       = {rs1, rs0};
        id_rs_used  = used;
        id_rd       = rd;
        id_regwrite = rw;
        id_memread  = mr;
        id_memwrite = mw;
        flush       = fl;
        #2;
    endtask

    task automatic nop();
        drive(1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Compare both DUTs against the model, then clock and advance the model.
    task automatic tick(input string tag);
        logic   s [2];
        instr_t cur;
        cur = id_instr();
        for (int m = 0; m < 2; m++) begin
            s[m] = model_stall(m);
            check($sformatf("%s.m%0d.stall", tag, m), 32'(m == 1 ? stall1 : stall0), 32'(s[m]));
            check($sformatf("%s.m%0d.sel", tag, m), 32'(m == 1 ? sel1 : sel0), 32'(model_sel(m)));
            check($sformatf("%s.m%0d.mfe", tag, m), 32'(m == 1 ? mfe1 : mfe0), 32'(model_mfe(m)));
            check($sformatf("%s.m%0d.cnt", tag, m), (m == 1) ? 32'(cnt1) : 32'(cnt0), cnt[m]);
        end
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                for (int k = 0; k < 3; k++) pipe[m][k] = '0;
                cnt[m] = 0;
            end else begin
                if (s[m] && cnt[m] < ((m == 1) ? 32'd15 : 32'd65535)) cnt[m]++;
                pipe[m][2] = pipe[m][1];
                pipe[m][1] = pipe[m][0];
                pipe[m][0] = (cur.valid && !s[m] && !flush) ? cur : '0;
            end
        end
        #1;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 3; k++) begin
            nop();
            tick(tag);
        end
    endtask

    initial begin
        rst = 1'b1;
        nop();
        repeat (2) @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 3; k++) pipe[m][k] = '0;
            cnt[m] = 0;
        end
        #1;
        rst = 1'b0;

        // Reset state
        nop();
        check("reset.sel", 32'(sel1), 32'd0);
        check("reset.cnt", 32'(cnt1), 32'd0);
        tick("reset");

        // add r3,r1,r2 ; sub r4,r3,r5 -> EX/MEM forward on source 0
        drive(1, 4'd1, 4'd2, 2'b11, 4'd3, 1, 0, 0, 0); tick("ex_ex");
        drive(1, 4'd3, 4'd5, 2'b11, 4'd4, 1, 0, 0, 0); tick("ex_ex");
        nop();
        check("ex_ex.sel", 32'(sel1), 32'h2);
        check("ex_ex.stall", 32'(stall1), 32'd0);
        tick("ex_ex");
        drain("ex_ex");

        // add r3 ; add r7,r8,r9 ; sub r4,r3,r3 -> both sources from MEM/WB
        drive(1, 4'd1, 4'd2, 2'b11, 4'd3, 1, 0, 0, 0); tick("mem_ex");
        drive(1, 4'd8, 4'd9, 2'b11, 4'd7, 1, 0, 0, 0); tick("mem_ex");
        drive(1, 4'd3, 4'd3, 2'b11, 4'd4, 1, 0, 0, 0); tick("mem_ex");
        nop();
        check("mem_ex.sel", 32'(sel1), 32'h5);
        tick("mem_ex");
        drain("mem_ex");

        // add r3 ; or r3 ; and r6,r3,r0 -> the younger producer in MEM wins
        drive(1, 4'd1, 4'd2, 2'b11, 4'd3, 1, 0, 0, 0); tick("prio");
        drive(1, 4'd4, 4'd5, 2'b11, 4'd3, 1, 0, 0, 0); tick("prio");
        drive(1, 4'd3, 4'd0, 2'b11, 4'd6, 1, 0, 0, 0); tick("prio");
        nop();
        check("prio.sel", 32'(sel1), 32'h2);
        tick("prio");
        drain("prio");

        // ld r0 ; add r1,r0,r0 -> r0 never forwards and never stalls
        drive(1, 4'd2, 4'd0, 2'b01, 4'd0, 1, 1, 0, 0); tick("r0");
        drive(1, 4'd0, 4'd0, 2'b11, 4'd1, 1, 0, 0, 0);
        check("r0.stall", 32'(stall1), 32'd0);
        tick("r0");
        nop();
        check("r0.sel", 32'(sel1), 32'd0);
        tick("r0");
        drain("r0");

        // Reset mid-stream discards the in-flight add
        drive(1, 4'd1, 4'd2, 2'b11, 4'd3, 1, 0, 0, 0); tick("mid_rst");
        rst = 1'b1;
        drive(1, 4'd3, 4'd5, 2'b11, 4'd4, 1, 0, 0, 0); tick("mid_rst");
        rst = 1'b0;
        nop();
        check("mid_rst.sel", 32'(sel1), 32'd0);
        check("mid_rst.mfe", 32'(mfe1), 32'd0);
        check("mid_rst.cnt", 32'(cnt0), 32'd0);
        tick("mid_rst");

        // ld r5 ; add r6,r5,r1 -> one stall, then WB forward
        drive(1, 4'd2, 4'd0, 2'b01, 4'd5, 1, 1, 0, 0); tick("ld_use");
        drive(1, 4'd5, 4'd1, 2'b11, 4'd6, 1, 0, 0, 0);
        check("ld_use.stall1", 32'(stall1), 32'd1);
        check("ld_use.stall0", 32'(stall0), 32'd1);
        tick("ld_use");
        drive(1, 4'd5, 4'd1, 2'b11, 4'd6, 1, 0, 0, 0);
        check("ld_use.restall", 32'(stall1), 32'd0);
        check("ld_use.bubble", 32'(sel1), 32'd0);
        tick("ld_use");
        nop();
        check("ld_use.sel", 32'(sel1), 32'h1);
        check("ld_use.cnt", 32'(cnt1), 32'd1);
        tick("ld_use");
        drain("ld_use");

        // ld r5 ; st r5 -> [r2]: forwarding build does not stall
        drive(1, 4'd2, 4'd0, 2'b01, 4'd5, 1, 1, 0, 0); tick("st_fwd");
        drive(1, 4'd2, 4'd5, 2'b11, 4'd0, 0, 0, 1, 0);
        check("st_fwd.stall1", 32'(stall1), 32'd0);
        check("st_fwd.stall0", 32'(stall0), 32'd1);
        tick("st_fwd");
        drive(1, 4'd2, 4'd5, 2'b11, 4'd0, 0, 0, 1, 0); tick("st_fwd");
        nop();
        check("st_fwd.mfe1", 32'(mfe1), 32'd1);
        check("st_fwd.mfe0", 32'(mfe0), 32'd0);
        tick("st_fwd");
        drain("st_fwd");

        // Load-use coinciding with flush: no stall, no count
        drive(1, 4'd2, 4'd0, 2'b01, 4'd5, 1, 1, 0, 0); tick("flush");
        drive(1, 4'd5, 4'd1, 2'b11, 4'd6, 1, 0, 0, 1);
        check("flush.stall", 32'(stall1), 32'd0);
        tick("flush");
        drain("flush");

        // Drive the 4-bit counter into saturation
        for (int k = 0; k < 16; k++) begin
            drive(1, 4'd2, 4'd0, 2'b01, 4'd5, 1, 1, 0, 0); tick("sat");
            drive(1, 4'd5, 4'd1, 2'b11, 4'd6, 1, 0, 0, 0); tick("sat");
            drive(1, 4'd5, 4'd1, 2'b11, 4'd6, 1, 0, 0, 0); tick("sat");
        end
        nop();
        check("sat.cnt1", 32'(cnt1), 32'd15);
        check("sat.cnt0", 32'(cnt0), 32'd18);
        tick("sat");

        // Randomized traffic over a small register set to provoke hazards
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 9) < 8,
                  4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0,
                  1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0);
            tick("rnd");
        end
        rst = 1'b0;
        drain("rnd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
